// File: rtl/calc_pkg.sv
// Shared definitions for the stack-calculator command driver: bus command codes,
// one-hot op codes, driver FSM states and response status bit positions.
package calc_pkg;

    localparam logic [3:0] COM_START   = 4'h1;
    localparam logic [3:0] COM_ENTER   = 4'h2;
    localparam logic [3:0] COM_ARITHOP = 4'h4;
    localparam logic [3:0] COM_DONE    = 4'h8;

    localparam logic [15:0] OP_ADD  = 16'h0001;
    localparam logic [15:0] OP_SUB  = 16'h0002;
    localparam logic [15:0] OP_AND  = 16'h0004;
    localparam logic [15:0] OP_SWAP = 16'h0008;
    localparam logic [15:0] OP_NEG  = 16'h0010;
    localparam logic [15:0] OP_POP  = 16'h0020;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE,
        ST_WAIT_FIN,
        ST_RESP
    } drv_state_e;

    localparam int STAT_SOVF    = 0;
    localparam int STAT_UDONE   = 1;
    localparam int STAT_DOVF    = 2;
    localparam int STAT_PERR    = 3;
    localparam int STAT_CORRECT = 4;
    localparam int STAT_PRED    = 5;
    localparam int STAT_TMO     = 6;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [15:0] payload;
    } calc_word_t;

endpackage

// File: rtl/calc_depth_tracker.sv
// Predicts the calculator stack depth from the accepted token stream and raises a
// sticky pred_err when a token would underflow, overflow or is not a known op.
module calc_depth_tracker
    import calc_pkg::*;
#(
    parameter int MAX_DEPTH = 8
) (
    input  logic        ck_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        accept_i,
    input  logic        first_i,
    input  logic        is_op_i,
    input  logic [15:0] payload_i,
    output logic        pred_err_o
);

    localparam int DW = $clog2(MAX_DEPTH + 1);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] ONE   = DW'(1);
    localparam logic [DW-1:0] TWO   = DW'(2);

    logic [DW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic          viol;

    always_comb begin
        depth_d = depth_q;
        err_d   = err_q;
        viol    = 1'b0;
        if (clr_i) begin
            depth_d = '0;
            err_d   = 1'b0;
        end else if (accept_i) begin
            if (!is_op_i) begin
                if (first_i) begin
                    depth_d = ONE;
                end else if (depth_q == MAX_D) begin
                    viol = 1'b1;
                end else begin
                    depth_d = depth_q + ONE;
                end
            end else if (first_i) begin
                // An op as the very first token always operates on an empty stack.
                viol = 1'b1;
            end else begin
                case (payload_i)
                    OP_ADD, OP_SUB, OP_AND: begin
                        viol    = (depth_q < TWO);
                        depth_d = (depth_q != '0) ? depth_q - ONE : '0;
                    end
                    OP_POP: begin
                        viol    = (depth_q == '0);
                        depth_d = (depth_q != '0) ? depth_q - ONE : '0;
                    end
                    OP_SWAP: viol = (depth_q < TWO);
                    OP_NEG:  viol = (depth_q == '0);
                    default: viol = 1'b1;
                endcase
            end
            if (viol) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign pred_err_o = err_q;

endmodule

// File: rtl/calc_cmd_driver.sv
// Serialises an upstream token stream onto the calculator command bus, waits for
// the calculator to finish and hands the result plus accumulated status back upstream.
module calc_cmd_driver
    import calc_pkg::*;
#(
    parameter int MAX_DEPTH   = 8,
    parameter int FIN_TIMEOUT = 16
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_op,
    input  logic [15:0] in_payload,
    input  logic        in_last,
    output logic [19:0] data,
    input  logic [15:0] result,
    input  logic        stackOverflow,
    input  logic        unexpectedDone,
    input  logic        dataOverflow,
    input  logic        protocolError,
    input  logic        correct,
    input  logic        finished,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_result,
    output logic [6:0]  resp_status,
    output logic        busy
);

    localparam int CW = $clog2(FIN_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FIN_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    drv_state_e  state_q;
    calc_word_t  data_q;
    logic        resp_valid_q;
    logic [15:0] resp_result_q;
    logic [3:0]  flags_q;
    logic        correct_q;
    logic        tmo_q;
    logic        busy_q;
    logic [CW-1:0] cnt_q;

    logic       accept;
    logic       resp_take;
    logic       pred_err;
    logic [3:0] err_flags;

    assign in_ready  = !rst && (state_q == ST_IDLE || state_q == ST_STREAM);
    assign accept    = in_valid && in_ready;
    assign resp_take = (state_q == ST_RESP) && resp_ready;
    assign err_flags = {protocolError, dataOverflow, unexpectedDone, stackOverflow};

    calc_depth_tracker #(
        .MAX_DEPTH (MAX_DEPTH)
    ) u_depth (
        .ck_i       (ck),
        .rst_i      (rst),
        .clr_i      (resp_take),
        .accept_i   (accept),
        .first_i    (state_q == ST_IDLE),
        .is_op_i    (in_is_op),
        .payload_i  (in_payload),
        .pred_err_o (pred_err)
    );

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            data_q        <= '0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            flags_q       <= '0;
            correct_q     <= 1'b0;
            tmo_q         <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            // Each token word is on the bus for one cycle only; otherwise idle word.
            data_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        data_q  <= in_is_op ? {COM_ARITHOP, in_payload} : {COM_START, in_payload};
                        state_q <= in_last ? ST_DONE : ST_STREAM;
                        busy_q  <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    flags_q <= flags_q | err_flags;
                    if (accept) begin
                        data_q <= in_is_op ? {COM_ARITHOP, in_payload} : {COM_ENTER, in_payload};
                        if (in_last) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    flags_q <= flags_q | err_flags;
                    data_q  <= {COM_DONE, 16'h0000};
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_FIN;
                end
                ST_WAIT_FIN: begin
                    flags_q <= flags_q | err_flags;
                    if (finished) begin
                        resp_result_q <= result;
                        correct_q     <= correct;
                        resp_valid_q  <= 1'b1;
                        state_q       <= ST_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        tmo_q         <= 1'b1;
                        resp_result_q <= '0;
                        resp_valid_q  <= 1'b1;
                        state_q       <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        flags_q      <= '0;
                        correct_q    <= 1'b0;
                        tmo_q        <= 1'b0;
                        cnt_q        <= '0;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        resp_status               = '0;
        resp_status[STAT_SOVF]    = flags_q[0];
        resp_status[STAT_UDONE]   = flags_q[1];
        resp_status[STAT_DOVF]    = flags_q[2];
        resp_status[STAT_PERR]    = flags_q[3];
        resp_status[STAT_CORRECT] = correct_q;
        resp_status[STAT_PRED]    = pred_err;
        resp_status[STAT_TMO]     = tmo_q;
    end

    assign data        = data_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_calc_cmd_driver.sv
// Directed bench for calc_cmd_driver: token serialisation, bubbles, depth prediction,
// finish timeout, mid-sequence reset and response hold.
module tb_calc_cmd_driver;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_is_op = 1'b0;
    logic [15:0] in_payload = '0;
    logic        in_last = 1'b0;
    logic [19:0] data;
    logic [15:0] result = '0;
    logic        stackOverflow = 1'b0;
    logic        unexpectedDone = 1'b0;
    logic        dataOverflow = 1'b0;
    logic        protocolError = 1'b0;
    logic        correct = 1'b0;
    logic        finished = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_result;
    logic [6:0]  resp_status;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int n;

    calc_cmd_driver #(.MAX_DEPTH(8), .FIN_TIMEOUT(16)) dut (
        .ck             (ck),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_is_op       (in_is_op),
        .in_payload     (in_payload),
        .in_last        (in_last),
        .data           (data),
        .result         (result),
        .stackOverflow  (stackOverflow),
        .unexpectedDone (unexpectedDone),
        .dataOverflow   (dataOverflow),
        .protocolError  (protocolError),
        .correct        (correct),
        .finished       (finished),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_result    (resp_result),
        .resp_status    (resp_status),
        .busy           (busy)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tok(input logic op, input logic [15:0] p, input logic last);
        @(negedge ck);
        in_valid = 1'b1; in_is_op = op; in_payload = p; in_last = last;
        @(posedge ck); #1;
    endtask

    task automatic gap();
        @(negedge ck);
        in_valid = 1'b0; in_is_op = 1'b0; in_payload = '0; in_last = 1'b0;
        @(posedge ck); #1;
    endtask

    task automatic finish_calc(input logic [15:0] r, input logic c, input logic [3:0] fl);
        @(negedge ck);
        in_valid = 1'b0; finished = 1'b1; result = r; correct = c;
        {protocolError, dataOverflow, unexpectedDone, stackOverflow} = fl;
        @(posedge ck); #1;
        finished = 1'b0; correct = 1'b0;
        {protocolError, dataOverflow, unexpectedDone, stackOverflow} = 4'b0000;
    endtask

    task automatic release_resp(input string tag);
        @(negedge ck);
        resp_ready = 1'b1;
        @(posedge ck); #1;
        resp_ready = 1'b0;
        chk({tag, "_rel_valid"}, resp_valid, 0);
        chk({tag, "_rel_status"}, resp_status, 0);
        chk({tag, "_rel_busy"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        @(posedge ck); @(posedge ck); #1;
        chk("rst_data", data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_status", resp_status, 0);
        chk("rst_result", resp_result, 0);
        @(negedge ck); rst = 1'b0; #1;
        chk("idle_in_ready", in_ready, 1);

        // 1: back-to-back 1,2,3,POP,ADD(last)
        tok(0, 16'h0001, 0); chk("t1_w0", data, 20'h10001); chk("t1_busy", busy, 1);
        tok(0, 16'h0002, 0); chk("t1_w1", data, 20'h20002);
        tok(0, 16'h0003, 0); chk("t1_w2", data, 20'h20003);
        tok(1, 16'h0020, 0); chk("t1_w3", data, 20'h40020);
        tok(1, 16'h0001, 1); chk("t1_w4", data, 20'h40001); chk("t1_done_rdy", in_ready, 0);
        gap();               chk("t1_w5", data, 20'h80000);
        finish_calc(16'd3, 1'b1, 4'b0000);
        chk("t1_valid", resp_valid, 1);
        chk("t1_result", resp_result, 3);
        chk("t1_status", resp_status, 7'b0010000);
        release_resp("t1");

        // 2: bubbles between tokens
        tok(0, 16'h0001, 0); chk("t2_w0", data, 20'h10001);
        gap();               chk("t2_b0", data, 0);
        tok(0, 16'h0002, 0); chk("t2_w1", data, 20'h20002);
        gap();               chk("t2_b1", data, 0);
        gap();               chk("t2_b2", data, 0);
        tok(0, 16'h0003, 0); chk("t2_w2", data, 20'h20003);
        tok(1, 16'h0020, 0); chk("t2_w3", data, 20'h40020);
        gap();               chk("t2_b3", data, 0);
        tok(1, 16'h0001, 1); chk("t2_w4", data, 20'h40001);
        gap();               chk("t2_w5", data, 20'h80000);
        finish_calc(16'd3, 1'b1, 4'b0000);
        chk("t2_result", resp_result, 3);
        chk("t2_status", resp_status, 7'b0010000);
        release_resp("t2");

        // 3: ADD as first and last token; protocolError pulsed during DONE must stick
        tok(1, 16'h0001, 1); chk("t3_w0", data, 20'h40001);
        @(negedge ck); in_valid = 1'b0; protocolError = 1'b1;
        @(posedge ck); #1; protocolError = 1'b0;
        chk("t3_w1", data, 20'h80000);
        finish_calc(16'h00AA, 1'b0, 4'b0000);
        chk("t3_result", resp_result, 16'h00AA);
        chk("t3_status", resp_status, 7'b0101000);
        release_resp("t3");

        // 4a: exactly MAX_DEPTH pushes is legal
        for (int i = 1; i <= 8; i++) begin
            tok(0, 16'(i), (i == 8));
            if (i == 1) chk("t4a_w0", data, 20'h10001);
        end
        chk("t4a_w7", data, 20'h20008);
        gap(); chk("t4a_done", data, 20'h80000);
        finish_calc(16'd8, 1'b1, 4'b0000);
        chk("t4a_status", resp_status, 7'b0010000);
        release_resp("t4a");

        // 4: ninth push overflows the predicted depth
        for (int i = 1; i <= 9; i++) tok(0, 16'(i), (i == 9));
        chk("t4_w8", data, 20'h20009);
        gap(); chk("t4_done", data, 20'h80000);
        finish_calc(16'd9, 1'b0, 4'b0001);
        chk("t4_result", resp_result, 9);
        chk("t4_status", resp_status, 7'b0100001);
        release_resp("t4");

        // 5: finished never arrives
        tok(0, 16'h0007, 1); chk("t5_w0", data, 20'h10007);
        result = 16'hBEEF;
        gap(); chk("t5_done", data, 20'h80000);
        n = 0;
        do begin
            @(posedge ck); #1;
            n++;
        end while (!resp_valid && n < 40);
        chk("t5_latency", n, 16);
        chk("t5_valid", resp_valid, 1);
        chk("t5_status", resp_status, 7'b1000000);
        chk("t5_result", resp_result, 0);
        chk("t5_data", data, 0);
        release_resp("t5");

        // 6: reset mid-stream, then a fresh sequence with a stalled response
        tok(0, 16'h0011, 0); chk("t6_w0", data, 20'h10011);
        tok(0, 16'h0022, 0); chk("t6_w1", data, 20'h20022);
        @(negedge ck); rst = 1'b1; in_valid = 1'b0;
        @(posedge ck); #1;
        chk("t6_rst_data", data, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rdy", in_ready, 0);
        @(negedge ck); rst = 1'b0; #1;
        chk("t6_post_rdy", in_ready, 1);
        chk("t6_post_data", data, 0);
        chk("t6_post_valid", resp_valid, 0);
        tok(0, 16'h0005, 1); chk("t6_w2", data, 20'h10005);
        gap();               chk("t6_done", data, 20'h80000);
        finish_calc(16'd5, 1'b1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            chk("t6_hold_valid", resp_valid, 1);
            chk("t6_hold_result", resp_result, 5);
            chk("t6_hold_status", resp_status, 7'b0010000);
            chk("t6_hold_rdy", in_ready, 0);
            @(posedge ck); #1;
        end
        release_resp("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_cmd_driver.md
Name: calc_cmd_driver

Overview:
Hardware initiator for the stack-calculator command bus. It takes a token stream (values and ops) from an upstream producer over valid/ready and serialises it onto the 20-bit `{cmd[3:0], payload[15:0]}` data bus, one word per cycle: START for the first value, ENTER for later values, ARITHOP for ops, then DONE after the last token. It then waits for the calculator's `finished` and returns the final result plus accumulated status to the upstream side over a second valid/ready handshake. It sits between a test or sequence source and the `calculator` block.

Parameters:
MAX_DEPTH, 8, predicted stack depth limit; a push beyond it sets the pred_err status bit.
FIN_TIMEOUT, 16, cycles to wait for `finished` after DONE before reporting a timeout.

Ports:
ck  in  1  clock; all logic on posedge.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  upstream token valid.
in_ready  out  1  driver accepts the token this cycle.
in_is_op  in  1  1 = payload is an op code; 0 = payload is a value.
in_payload  in  16  value, or one-hot op (ADD 0x1, SUB 0x2, AND 0x4, SWAP 0x8, NEG 0x10, POP 0x20).
in_last  in  1  last token of the sequence.
data  out  20  command word to the calculator.
result  in  16  calculator top-of-stack.
stackOverflow, unexpectedDone, dataOverflow, protocolError, correct, finished  in  1 each  calculator flags.
resp_valid  out  1  response available.
resp_ready  in  1  upstream consumes the response.
resp_result  out  16  result sampled at `finished`.
resp_status  out  7  [0] stackOverflow, [1] unexpectedDone, [2] dataOverflow, [3] protocolError, [4] correct, [5] pred_err, [6] timeout.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (`rst` high at posedge), taking priority over everything, including mid-sequence:
  - state = IDLE; data = 20'h0 (idle word, cmd 0).
  - in_ready = 0, resp_valid = 0, resp_result = 0, resp_status = 0, busy = 0.
  - depth = 0, timeout counter = 0.
- All outputs are registered. in_ready is combinational from state: high only in IDLE and STREAM.
- IDLE: on accept (in_valid && in_ready):
  - value → data = {4'h1, payload}, depth = 1.
  - op → data = {4'h4, payload}, pred_err set.
  - Next state: in_last ? DONE : STREAM.
- STREAM, on accept:
  - value → {4'h2, payload}, depth + 1.
  - op → {4'h4, payload}.
  - Depth rules for ops:
    - ADD/SUB/AND/POP: need depth ≥ 2 (≥ 1 for POP); depth − 1.
    - SWAP: needs ≥ 2; depth unchanged.
    - NEG: needs ≥ 1; depth unchanged.
    - Violation: set pred_err; depth saturates at 0.
  - Non-one-hot or unknown op: sent unchanged; pred_err set.
  - Push with depth == MAX_DEPTH: pred_err set; depth saturates.
  - No accept in a cycle → data = 20'h0 (bubble).
  - After accepting in_last → DONE.
- DONE: data = {4'h8, 16'h0} for exactly one cycle; in_ready low; → WAIT_FIN with counter = 0.
- WAIT_FIN:
  - data = 20'h0.
  - Error flags [3:0] are sticky-ORed every cycle from the first word sent until leaving WAIT_FIN.
  - On `finished`: latch result into resp_result, latch correct into status[4]; → RESP.
  - If counter reaches FIN_TIMEOUT−1 without `finished`: set status[6]; resp_result = 0; → RESP.
- RESP: resp_valid = 1 with status and result held stable. On resp_ready → IDLE; clear status, depth and counter. An IDLE token is not accepted in the same cycle.
- Throughput: one token per cycle. Latency from accepting in_last to DONE appearing on data is 1 cycle.
- The calculator must see a token word on the bus for exactly one cycle after the accepting posedge.

Decomposition:
- Package `calc_pkg`:
  - command codes COM_START/ENTER/ARITHOP/DONE.
  - op codes OP_ADD..OP_POP.
  - driver state enum.
  - status bit index constants.
  - `typedef calc_word_t {logic [3:0] cmd; logic [15:0] payload;}`.
- One natural sub-module: `calc_depth_tracker` (depth counter plus pred_err generation from is_op/payload/accept).

Test Plan:
1. Tokens 1(v), 2(v), 3(v), POP, ADD(last), back-to-back:
   - data = 10001, 20002, 20003, 40020, 40001, 80000 on consecutive cycles.
   - Calculator `finished`: resp_result = 3, status = 7'b0010000.
2. in_valid gaps between tokens: data shows 20'h0 bubbles; word order unchanged; same result 3.
3. First token ADD(last):
   - data = 40001 then 80000.
   - pred_err = 1; calculator protocol/flag bits reflected in status.
4. 9 value pushes with MAX_DEPTH = 8: pred_err set on the 9th accept; calculator stackOverflow captured in status[0].
5. Model that never asserts `finished`: resp_valid exactly FIN_TIMEOUT cycles after WAIT_FIN entry; status[6] = 1; resp_result = 0.
6. rst pulsed in STREAM after 2 tokens:
   - next cycle data = 0, in_ready = 1, resp_valid = 0.
   - A fresh sequence 5(v, last) → data 10005, 80000, resp_result 5.
   - resp_ready held low 3 cycles → resp_valid and fields stable.
